dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Downstream of the synth top-level mixer output.
- Takes the 16-bit unsigned mixed sample and serialises it as 16-bit write frames to an external 12-bit SPI DAC (MCP4922-style: 4 config bits + 12 data bits, MSB first).
- Holds one pending sample; a newer sample replaces an unsent one (latest-wins) and increments a saturating overrun counter.
- Drives CS, SCLK, MOSI and an LDAC strobe that updates the DAC output after each frame.

Parameters:
- CLK_DIV, 2, system-clock cycles per SCLK half-period (≥1); SCLK = f_clk/(2*CLK_DIV).
- CFG_BITS, 4'b0011, frame bits [15:12]: channel A, unbuffered, gain 1x, output active.
- LDAC_EN, 1, 1 = pulse o_dac_ldac_n after each frame; 0 = o_dac_ldac_n held high and LDAC state skipped.

Ports:
- i_clk  input  1  system clock (50 MHz).
- i_rst  input  1  synchronous, active-high reset.
- i_sample  input  16  unsigned sample, valid when i_sample_valid=1.
- i_sample_valid  input  1  one-cycle strobe; sample captured on that edge.
- o_dac_cs_n  output  1  DAC chip select, active low.
- o_dac_sclk  output  1  SPI clock, idle low, DAC samples MOSI on rising edge.
- o_dac_mosi  output  1  serial data, MSB first.
- o_dac_ldac_n  output  1  DAC latch strobe, active low.
- o_busy  output  1  high while a sample is pending or a frame is in flight.
- o_overrun_cnt  output  8  count of pending samples discarded by a newer one, saturates at 255.

Behaviour:
- Reset (i_rst=1 on an edge): next cycle cs_n=1, sclk=0, mosi=0, ldac_n=1, busy=0, overrun_cnt=0. Pending cleared, FSM→IDLE. Applies mid-frame: the frame is aborted with no LDAC pulse.
- Capture: i_sample_valid loads pend_data and sets pend_vld.
  - If pend_vld is already set and not consumed this cycle, overrun_cnt increments (saturating).
  - A valid arriving in the same cycle IDLE consumes pending becomes the new pending, with no overrun.
- Frame word: {CFG_BITS, sample[15:4]}; sample[3:0] discarded. No rounding.
- FSM states: IDLE, SHIFT, HOLD, GAP, LDAC.
- IDLE: cs_n=1, sclk=0. If pend_vld: load shift register, clear pend_vld, →SHIFT, bit index=15. Next cycle cs_n=0 and mosi=frame[15].
- SHIFT: each bit is CLK_DIV cycles with sclk=0 (mosi stable), then CLK_DIV cycles with sclk=1.
  - Mosi changes only on the cycle sclk falls, or on entry.
  - After the bit 0 high phase: sclk=0, →HOLD.
- HOLD: cs_n=0, sclk=0 for CLK_DIV cycles → GAP.
- GAP: cs_n=1 for CLK_DIV cycles → LDAC if LDAC_EN, else IDLE.
- LDAC: ldac_n=0 for CLK_DIV cycles → IDLE.
- Timing at defaults:
  - cs_n low for exactly 33*CLK_DIV = 66 cycles.
  - Exactly 16 rising SCLK edges per frame.
  - cs_n falls 2 cycles after an accepted i_sample_valid when IDLE with nothing pending.
  - Frame-to-frame cs_n high time ≥ 2*CLK_DIV+1 (LDAC_EN=1).
- mosi=0 whenever cs_n=1.
- busy = pend_vld OR state≠IDLE, registered (reflects state after the edge).
- Pending is captured in all states including HOLD/GAP/LDAC. A frame in flight is never modified by new samples.
- Counters use the minimum width for CLK_DIV and 16 bits. No combinational path from inputs to outputs.

Test Plan:
- Reset, then single valid with i_sample=16'hABCD, defaults → cs_n low 66 cycles starting 2 cycles later; MOSI bits on 16 SCLK rising edges = 16'h3ABC; ldac_n low 2 cycles starting 2 cycles after cs_n rises; busy returns 0 after.
- Valid 16'h1234, then 16'h5678 at cycle 10 and 16'h9ABC at cycle 20 (both mid-frame) → frames 16'h3123 then 16'h39AB; overrun_cnt=1; 16'h5678 never sent.
- Continuous valid every cycle for 400 cycles → frames back-to-back with ≥5 cycles cs_n high between; overrun_cnt saturates at 255 and holds.
- i_rst asserted at bit 8 of a frame → next cycle cs_n=1, sclk=0, ldac_n=1, busy=0, overrun_cnt=0; no LDAC pulse; next valid produces a full clean frame.
- CLK_DIV=1, LDAC_EN=0, sample 16'hFFFF → SCLK period 2 cycles, frame 16'h3FFF, cs_n low 33 cycles, ldac_n stays high.
- Valid coincident with IDLE consuming pending (two valids exactly at frame-end IDLE cycle) → new sample becomes pending, overrun_cnt unchanged, sent as next frame.

Source files
------------

// File: rtl/dac_spi_tx.sv
// SPI write-frame serialiser for an MCP4922-style 12-bit DAC, fed by the synth mixer.
// One latest-wins pending slot; a saturating counter records samples dropped unsent.
module dac_spi_tx #(
   parameter int unsigned CLK_DIV  = 2,
   parameter logic [3:0]  CFG_BITS = 4'b0011,
   parameter bit          LDAC_EN  = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_sample,
   input  logic        i_sample_valid,
   output logic        o_dac_cs_n,
   output logic        o_dac_sclk,
   output logic        o_dac_mosi,
   output logic        o_dac_ldac_n,
   output logic        o_busy,
   output logic [7:0]  o_overrun_cnt
);

   localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP,
      LDAC
   } state_e;

   state_e           state_q, state_d;
   logic             pend_vld_q, pend_vld_d;
   logic [11:0]      pend_data_q, pend_data_d;
   logic [15:0]      shift_q, shift_d;
   logic [3:0]       bit_q, bit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             phase_q, phase_d;
   logic [7:0]       overrun_q, overrun_d;
   logic             consume;
   logic             div_done;

   // The DAC only has 12 bits of resolution; the low nibble is truncated.
   logic sample_lsb_unused;
   assign sample_lsb_unused = ^i_sample[3:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         pend_vld_q  <= 1'b0;
         pend_data_q <= '0;
         shift_q     <= '0;
         bit_q       <= '0;
         div_q       <= '0;
         phase_q     <= 1'b0;
         overrun_q   <= '0;
      end else begin
         state_q     <= state_d;
         pend_vld_q  <= pend_vld_d;
         pend_data_q <= pend_data_d;
         shift_q     <= shift_d;
         bit_q       <= bit_d;
         div_q       <= div_d;
         phase_q     <= phase_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_vld_d  = pend_vld_q;
      pend_data_d = pend_data_q;
      shift_d     = shift_q;
      bit_d       = bit_q;
      phase_d     = phase_q;
      overrun_d   = overrun_q;
      consume     = 1'b0;
      div_done    = (div_q == DIV_LAST);
      div_d       = div_done ? '0 : div_q + 1'b1;

      case (state_q)
         IDLE: begin
            div_d   = '0;
            phase_d = 1'b0;
            if (pend_vld_q) begin
               consume = 1'b1;
               shift_d = {CFG_BITS, pend_data_q};
               bit_d   = 4'd15;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (div_done) begin
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  // Advance MOSI only on the falling SCLK so it is stable across the rise.
                  if (bit_q == 4'd0) begin
                     state_d = HOLD;
                  end else begin
                     bit_d   = bit_q - 1'b1;
                     shift_d = {shift_q[14:0], 1'b0};
                  end
               end
            end
         end
         HOLD: begin
            if (div_done) state_d = GAP;
         end
         GAP: begin
            if (div_done) begin
               if (LDAC_EN) state_d = LDAC;
               else         state_d = IDLE;
            end
         end
         LDAC: begin
            if (div_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A sample arriving while IDLE takes the old one is the new pending, not an overrun.
      if (i_sample_valid) begin
         pend_data_d = i_sample[15:4];
         pend_vld_d  = 1'b1;
         if (pend_vld_q && !consume && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
      end else if (consume) begin
         pend_vld_d = 1'b0;
      end
   end

   assign o_dac_cs_n    = !((state_q == SHIFT) || (state_q == HOLD));
   assign o_dac_sclk    = (state_q == SHIFT) && phase_q;
   assign o_dac_mosi    = ((state_q == SHIFT) || (state_q == HOLD)) && shift_q[15];
   assign o_dac_ldac_n  = !(LDAC_EN && (state_q == LDAC));
   assign o_busy        = pend_vld_q || (state_q != IDLE);
   assign o_overrun_cnt = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: a transaction/timing model predicts every output
// cycle by cycle, and an SPI bus decoder reassembles frames for table and scenario checks.
module tb_dac_spi_tx;

   localparam int         D         = 2;
   localparam int         FRAME_CYC = 35 * D;
   localparam logic [3:0] CFG       = 4'b0011;

   typedef struct {
      logic [15:0] word;
      int          edges;
      int          lowLen;
   } frame_t;

   typedef struct {
      logic [15:0] sample;
      logic [15:0] expFrame;
   } vec_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [15:0] i_sample;
   logic        i_sample_valid;
   logic        o_dac_cs_n, o_dac_sclk, o_dac_mosi, o_dac_ldac_n, o_busy;
   logic [7:0]  o_overrun_cnt;

   logic [15:0] s1Sample;
   logic        s1Valid;
   logic        d1CsN, d1Sclk, d1Mosi, d1LdacN, d1Busy;
   logic [7:0]  d1Overrun;

   int checks = 0;
   int passes = 0;

   // Reference model state: pending slot, overrun count and the frame timeline.
   int          edgeNo = -1;
   bit          mPend = 1'b0;
   logic [15:0] mPendSample = '0;
   int          mCnt = 0;
   int          mIdleAt = 0;
   int          mStart = 0;
   bit          mActive = 1'b0;
   logic [15:0] mFrame = '0;
   logic [15:0] expQ[$];

   // Bus decoder state for both instances.
   frame_t      capQ[$];
   bit          monIn = 1'b0, monPrevSclk = 1'b0, monPrevLdac = 1'b1;
   int          monLow = 0, monEdges = 0, ldacPulses = 0;
   logic [15:0] monWord = '0;
   frame_t      d1Q[$];
   bit          d1In = 1'b0, d1PrevSclk = 1'b0;
   int          d1Low = 0, d1Edges = 0, d1LastRise = -1;
   int          d1BadPeriod = 0, d1LdacLow = 0, d1MosiBad = 0;
   logic [15:0] d1Word = '0;

   vec_t vecs[6];

   always #10 i_clk = ~i_clk;

   dac_spi_tx dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_sample(i_sample), .i_sample_valid(i_sample_valid),
      .o_dac_cs_n(o_dac_cs_n), .o_dac_sclk(o_dac_sclk), .o_dac_mosi(o_dac_mosi),
      .o_dac_ldac_n(o_dac_ldac_n), .o_busy(o_busy), .o_overrun_cnt(o_overrun_cnt)
   );

   dac_spi_tx #(.CLK_DIV(1), .CFG_BITS(4'b0011), .LDAC_EN(1'b0)) dut1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_sample(s1Sample), .i_sample_valid(s1Valid),
      .o_dac_cs_n(d1CsN), .o_dac_sclk(d1Sclk), .o_dac_mosi(d1Mosi),
      .o_dac_ldac_n(d1LdacN), .o_busy(d1Busy), .o_overrun_cnt(d1Overrun)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at edge %0d", name, actual, expected, edgeNo);
   endtask

   task automatic modelEdge();
      bit consume;
      edgeNo++;
      if (i_rst) begin
         if (mActive && ((edgeNo - mStart) <= 33 * D)) void'(expQ.pop_back());
         mActive = 1'b0;
         mPend   = 1'b0;
         mCnt    = 0;
         mIdleAt = edgeNo + 1;
         monIn   = 1'b0;
         d1In    = 1'b0;
      end else begin
         consume = mPend && (edgeNo >= mIdleAt);
         if (consume) begin
            mFrame  = {CFG, mPendSample[15:4]};
            mStart  = edgeNo;
            mActive = 1'b1;
            mIdleAt = edgeNo + FRAME_CYC + 1;
            expQ.push_back(mFrame);
         end
         if (i_sample_valid) begin
            if (mPend && !consume && mCnt < 255) mCnt++;
            mPend       = 1'b1;
            mPendSample = i_sample;
         end else if (consume) begin
            mPend = 1'b0;
         end
      end
   endtask

   task automatic checkCycle();
      int k;
      bit inFrame, expCs, expSclk, expLdac, expBusy;
      k       = edgeNo - mStart;
      inFrame = mActive && (k < FRAME_CYC);
      expCs   = !(inFrame && k < 33 * D);
      expSclk = inFrame && (k < 32 * D) && ((k % (2 * D)) >= D);
      expLdac = !(inFrame && k >= 34 * D);
      expBusy = mPend || inFrame;
      checkOutput("cs_n", 32'(o_dac_cs_n), 32'(expCs));
      checkOutput("sclk", 32'(o_dac_sclk), 32'(expSclk));
      checkOutput("ldac_n", 32'(o_dac_ldac_n), 32'(expLdac));
      checkOutput("busy", 32'(o_busy), 32'(expBusy));
      checkOutput("overrun", 32'(o_overrun_cnt), 32'(mCnt));
      if (expCs) checkOutput("mosi_idle", 32'(o_dac_mosi), 32'd0);
      else if (k < 32 * D) checkOutput("mosi_bit", 32'(o_dac_mosi), 32'(mFrame[15 - k / (2 * D)]));
   endtask

   task automatic monitorBus();
      frame_t f;
      if (o_dac_cs_n === 1'b0) begin
         if (!monIn) begin
            monIn = 1'b1; monLow = 0; monEdges = 0; monWord = '0;
         end
         monLow++;
         if (o_dac_sclk === 1'b1 && !monPrevSclk) begin
            monWord = {monWord[14:0], o_dac_mosi};
            monEdges++;
         end
      end else if (monIn) begin
         monIn = 1'b0;
         f.word = monWord; f.edges = monEdges; f.lowLen = monLow;
         capQ.push_back(f);
      end
      if (o_dac_ldac_n === 1'b0 && monPrevLdac) ldacPulses++;
      monPrevSclk = (o_dac_sclk === 1'b1);
      monPrevLdac = (o_dac_ldac_n !== 1'b0);

      if (d1CsN === 1'b0) begin
         if (!d1In) begin
            d1In = 1'b1; d1Low = 0; d1Edges = 0; d1Word = '0; d1LastRise = -1;
         end
         d1Low++;
         if (d1Sclk === 1'b1 && !d1PrevSclk) begin
            d1Word = {d1Word[14:0], d1Mosi};
            d1Edges++;
            if (d1LastRise >= 0 && (edgeNo - d1LastRise) != 2) d1BadPeriod++;
            d1LastRise = edgeNo;
         end
      end else begin
         if (d1In) begin
            d1In = 1'b0;
            f.word = d1Word; f.edges = d1Edges; f.lowLen = d1Low;
            d1Q.push_back(f);
         end
         if (d1Mosi !== 1'b0) d1MosiBad++;
      end
      if (d1LdacN !== 1'b1) d1LdacLow++;
      d1PrevSclk = (d1Sclk === 1'b1);
   endtask

   task automatic stepCycle();
      @(posedge i_clk);
      modelEdge();
      @(negedge i_clk);
      checkCycle();
      monitorBus();
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] s);
      i_sample_valid = v;
      i_sample       = s;
      stepCycle();
   endtask

   task automatic pulseReset();
      i_rst = 1'b1;
      applyStimulus(1'b0, 16'h0);
      i_rst = 1'b0;
   endtask

   task automatic waitIdle(input int maxCycles);
      int n = 0;
      while (o_busy !== 1'b0 && n < maxCycles) begin
         applyStimulus(1'b0, 16'h0);
         n++;
      end
      checkOutput("idle_reached", 32'(o_busy), 32'd0);
   endtask

   task automatic checkFrames(input string name);
      checkOutput({name, "_count"}, 32'(capQ.size()), 32'(expQ.size()));
      for (int i = 0; i < capQ.size() && i < expQ.size(); i++) begin
         checkOutput({name, "_word"}, 32'(capQ[i].word), 32'(expQ[i]));
         checkOutput({name, "_edges"}, 32'(capQ[i].edges), 32'd16);
         checkOutput({name, "_cslow"}, 32'(capQ[i].lowLen), 32'(33 * D));
      end
      capQ.delete();
      expQ.delete();
   endtask

   task automatic checkCapWord(input string name, input int idx, input logic [15:0] expWord);
      if (idx < capQ.size()) begin
         checkOutput(name, 32'(capQ[idx].word), 32'(expWord));
      end else begin
         checks++;
         $display("[TB] FAIL %s: got no frame, expected 0x%0h at edge %0d", name, expWord, edgeNo);
      end
   endtask

   task automatic d1Frame(input logic [15:0] sample, input logic [15:0] expWord);
      d1Q.delete();
      s1Sample = sample;
      s1Valid  = 1'b1;
      applyStimulus(1'b0, 16'h0);
      s1Valid  = 1'b0;
      repeat (45) applyStimulus(1'b0, 16'h0);
      checkOutput("d1_count", 32'(d1Q.size()), 32'd1);
      if (d1Q.size() > 0) begin
         checkOutput("d1_word", 32'(d1Q[0].word), 32'(expWord));
         checkOutput("d1_edges", 32'(d1Q[0].edges), 32'd16);
         checkOutput("d1_cslow", 32'(d1Q[0].lowLen), 32'd33);
      end
      checkOutput("d1_sclk_period", 32'(d1BadPeriod), 32'd0);
      checkOutput("d1_ldac_high", 32'(d1LdacLow), 32'd0);
      checkOutput("d1_mosi_idle", 32'(d1MosiBad), 32'd0);
      checkOutput("d1_busy", 32'(d1Busy), 32'd0);
      checkOutput("d1_overrun", 32'(d1Overrun), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int pulsesBefore;
      vecs[0] = '{16'hABCD, 16'h3ABC};
      vecs[1] = '{16'h0000, 16'h3000};
      vecs[2] = '{16'hFFFF, 16'h3FFF};
      vecs[3] = '{16'h800F, 16'h3800};
      vecs[4] = '{16'h0010, 16'h3001};
      vecs[5] = '{16'h5A5A, 16'h35A5};

      i_rst = 1'b1; i_sample_valid = 1'b0; i_sample = '0;
      s1Valid = 1'b0; s1Sample = '0;
      $display("[TB] start");
      pulseReset();
      pulseReset();

      // Single frames from a table: 2-cycle start latency, frame word, one LDAC pulse each.
      for (int i = 0; i < 6; i++) begin
         pulsesBefore = ldacPulses;
         applyStimulus(1'b1, vecs[i].sample);
         checkOutput("tbl_cs_before", 32'(o_dac_cs_n), 32'd1);
         applyStimulus(1'b0, 16'h0);
         checkOutput("tbl_cs_fall", 32'(o_dac_cs_n), 32'd0);
         checkOutput("tbl_first_bit", 32'(o_dac_mosi), 32'(vecs[i].expFrame[15]));
         waitIdle(200);
         checkCapWord("tbl_frame", 0, vecs[i].expFrame);
         checkOutput("tbl_ldac_pulses", 32'(ldacPulses - pulsesBefore), 32'd1);
         checkFrames("tbl");
      end

      // Mid-frame replacements: the middle sample is overwritten and counted.
      pulseReset();
      applyStimulus(1'b1, 16'h1234);
      repeat (9) applyStimulus(1'b0, 16'h0);
      applyStimulus(1'b1, 16'h5678);
      repeat (9) applyStimulus(1'b0, 16'h0);
      applyStimulus(1'b1, 16'h9ABC);
      waitIdle(300);
      checkOutput("latest_overrun", 32'(o_overrun_cnt), 32'd1);
      checkOutput("latest_count", 32'(capQ.size()), 32'd2);
      checkCapWord("latest_first", 0, 16'h3123);
      checkCapWord("latest_second", 1, 16'h39AB);
      checkFrames("latest");

      // Random sparse traffic against the model.
      for (int i = 0; i < 1500; i++)
         applyStimulus(1'($urandom_range(0, 39) == 0), 16'($urandom()));
      waitIdle(300);
      checkFrames("random");

      // Continuous valids: back-to-back frames and overrun saturation.
      pulseReset();
      for (int i = 0; i < 400; i++) applyStimulus(1'b1, 16'($urandom()));
      waitIdle(300);
      checkOutput("overrun_sat", 32'(o_overrun_cnt), 32'd255);
      checkFrames("stream");

      // Reset during bit 8 of a frame with an overrun already recorded.
      pulseReset();
      applyStimulus(1'b1, 16'hAAAA);
      applyStimulus(1'b1, 16'h5555);
      applyStimulus(1'b1, 16'h0F0F);
      checkOutput("abort_pre_overrun", 32'(o_overrun_cnt), 32'd1);
      repeat (28) applyStimulus(1'b0, 16'h0);
      checkOutput("abort_pre_cs", 32'(o_dac_cs_n), 32'd0);
      pulsesBefore = ldacPulses;
      pulseReset();
      checkOutput("abort_cs_n", 32'(o_dac_cs_n), 32'd1);
      checkOutput("abort_sclk", 32'(o_dac_sclk), 32'd0);
      checkOutput("abort_ldac_n", 32'(o_dac_ldac_n), 32'd1);
      checkOutput("abort_busy", 32'(o_busy), 32'd0);
      checkOutput("abort_overrun", 32'(o_overrun_cnt), 32'd0);
      repeat (100) applyStimulus(1'b0, 16'h0);
      checkOutput("abort_no_ldac", 32'(ldacPulses - pulsesBefore), 32'd0);
      checkOutput("abort_no_frame", 32'(capQ.size()), 32'd0);
      applyStimulus(1'b1, 16'hC3C3);
      waitIdle(200);
      checkCapWord("abort_clean_frame", 0, 16'h3C3C);
      checkFrames("abort");

      // A valid landing on the very edge IDLE takes the pending sample.
      pulseReset();
      applyStimulus(1'b1, 16'h1111);
      repeat (5) applyStimulus(1'b0, 16'h0);
      applyStimulus(1'b1, 16'h2222);
      n = 0;
      while (edgeNo + 1 < mIdleAt && n < 200) begin
         applyStimulus(1'b0, 16'h0);
         n++;
      end
      applyStimulus(1'b1, 16'h3333);
      checkOutput("coinc_overrun", 32'(o_overrun_cnt), 32'd0);
      checkOutput("coinc_busy", 32'(o_busy), 32'd1);
      waitIdle(400);
      checkOutput("coinc_count", 32'(capQ.size()), 32'd3);
      checkCapWord("coinc_first", 0, 16'h3111);
      checkCapWord("coinc_second", 1, 16'h3222);
      checkCapWord("coinc_third", 2, 16'h3333);
      checkFrames("coinc");

      // CLK_DIV=1, LDAC disabled instance.
      pulseReset();
      d1Frame(16'hFFFF, 16'h3FFF);
      d1Frame(16'h8421, 16'h3842);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
